// File: rtl/pflink_crc8_checker_if.sv
// pflink receive stream: word/CRC input, checked-word output and link status.
interface pflink_crc8_checker_if;
  localparam int unsigned DATA_W = 13;
  localparam int unsigned CRC_W  = 8;
  localparam int unsigned CNT_W  = 16;

  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic [CRC_W-1:0]  in_crc;
  logic              err_cnt_clr;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_crc_err;
  logic              locked;
  logic [CNT_W-1:0]  err_cnt;

  // Source side: drives words and the counter clear, observes the checker.
  modport master (
    output in_valid, in_data, in_crc, err_cnt_clr,
    input  out_valid, out_data, out_crc_err, locked, err_cnt
  );

  // Checker side.
  modport slave (
    input  in_valid, in_data, in_crc, err_cnt_clr,
    output out_valid, out_data, out_crc_err, locked, err_cnt
  );
endinterface

// File: rtl/pflink_crc8_checker.sv
// Receive-side CRC-8 checker for pflink 13-bit words: flags bad words,
// tracks link lock (HUNT/LOCKED) and counts bad words with saturation.
module pflink_crc8_checker #(
  parameter int unsigned LOCK_GOOD  = 16,
  parameter int unsigned UNLOCK_BAD = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  pflink_crc8_checker_if.slave  bus
);
  localparam int unsigned DATA_W = 13;
  localparam int unsigned CRC_W  = 8;
  localparam int unsigned RUN_W  = 8;
  localparam int unsigned CNT_W  = 16;
  localparam logic [CRC_W-1:0] POLY = 8'h07;
  localparam logic [RUN_W-1:0] LOCK_TH   = RUN_W'(LOCK_GOOD);
  localparam logic [RUN_W-1:0] UNLOCK_TH = RUN_W'(UNLOCK_BAD);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} state_t;

  state_t           state;
  logic [RUN_W-1:0] good_cnt;
  logic [RUN_W-1:0] bad_cnt;
  logic [CRC_W-1:0] exp_crc_c;
  logic             mismatch_c;
  logic             word_bad_c;
  logic             word_good_c;
  logic [RUN_W-1:0] good_inc_c;
  logic [RUN_W-1:0] bad_inc_c;

  // Serial CRC of the data word, d[12] first, init 0, no final XOR.
  always_comb begin
    logic fb;
    exp_crc_c = '0;
    fb        = 1'b0;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      fb        = exp_crc_c[CRC_W-1] ^ bus.in_data[i];
      exp_crc_c = {exp_crc_c[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
    end
  end

  assign mismatch_c  = (exp_crc_c != bus.in_crc);
  assign word_bad_c  = bus.in_valid & mismatch_c;
  assign word_good_c = bus.in_valid & ~mismatch_c;
  assign good_inc_c  = good_cnt + RUN_W'(1);
  assign bad_inc_c   = bad_cnt + RUN_W'(1);

  // Forward every valid word with its error flag; hold data on idle cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid   <= 1'b0;
      bus.out_data    <= '0;
      bus.out_crc_err <= 1'b0;
    end else begin
      bus.out_valid <= bus.in_valid;
      if (bus.in_valid) begin
        bus.out_data    <= bus.in_data;
        bus.out_crc_err <= mismatch_c;
      end
    end
  end

  // Lock tracker: advances only on valid words; locked decodes the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= HUNT;
      good_cnt   <= '0;
      bad_cnt    <= '0;
      bus.locked <= 1'b0;
    end else begin
      unique case (state)
        HUNT: begin
          if (word_bad_c) begin
            good_cnt <= '0;
          end else if (word_good_c) begin
            if (good_inc_c == LOCK_TH) begin
              state      <= LOCKED;
              good_cnt   <= '0;
              bad_cnt    <= '0;
              bus.locked <= 1'b1;
            end else begin
              good_cnt <= good_inc_c;
            end
          end
        end
        LOCKED: begin
          if (word_bad_c) begin
            if (bad_inc_c == UNLOCK_TH) begin
              state      <= HUNT;
              good_cnt   <= '0;
              bad_cnt    <= '0;
              bus.locked <= 1'b0;
            end else begin
              bad_cnt <= bad_inc_c;
            end
          end else if (word_good_c) begin
            bad_cnt <= '0;
          end
        end
        default: begin
          state      <= HUNT;
          good_cnt   <= '0;
          bad_cnt    <= '0;
          bus.locked <= 1'b0;
        end
      endcase
    end
  end

  // Saturating bad-word counter; a clear coinciding with a bad word leaves 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.err_cnt <= '0;
    end else if (word_bad_c) begin
      if (bus.err_cnt_clr) begin
        bus.err_cnt <= CNT_W'(1);
      end else if (bus.err_cnt != CNT_MAX) begin
        bus.err_cnt <= bus.err_cnt + CNT_W'(1);
      end
    end else if (bus.err_cnt_clr) begin
      bus.err_cnt <= '0;
    end
  end
endmodule

// File: tb/tb_pflink_crc8_checker.sv
// Directed + random bench for pflink_crc8_checker with a word scoreboard.
module tb_pflink_crc8_checker;
  localparam int unsigned LOCK_GOOD  = 16;
  localparam int unsigned UNLOCK_BAD = 4;

  typedef struct packed {
    logic [12:0] data;
    logic        crc_err;
  } entry_t;

  logic clk;
  logic rst;
  pflink_crc8_checker_if bus ();

  pflink_crc8_checker #(
    .LOCK_GOOD  (LOCK_GOOD),
    .UNLOCK_BAD (UNLOCK_BAD)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks = 0;
  int          fails  = 0;
  entry_t      q[$];
  logic        chk_en = 1'b0;
  logic        m_ov;
  logic [12:0] m_data;
  logic        m_cerr;
  logic        m_locked;
  logic [15:0] m_err;
  int          m_good;
  int          m_bad;

  // Reference CRC by polynomial long division of d * x^8 by 0x107.
  function automatic logic [7:0] crc_ref(input logic [12:0] d);
    logic [20:0] r;
    r = {d, 8'h00};
    for (int i = 20; i >= 8; i--)
      if (r[i]) r[i -: 9] = r[i -: 9] ^ 9'h107;
    return r[7:0];
  endfunction

  // Remainder of the full 21-bit codeword; zero means the word is good.
  function automatic logic [7:0] crc_rem(input logic [20:0] w);
    logic [20:0] r;
    r = w;
    for (int i = 20; i >= 8; i--)
      if (r[i]) r[i -: 9] = r[i -: 9] ^ 9'h107;
    return r[7:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare DUT outputs against the model state left by the previous edge.
  task automatic check_outputs();
    entry_t e;
    chk("out_valid", 32'(bus.out_valid), 32'(m_ov));
    if (m_ov) begin
      checks++;
      assert (q.size() != 0) else begin
        fails++;
        $error("FAIL sb_empty observed=%0d expected=%0d", q.size(), 1);
      end
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("sb_data", 32'(bus.out_data), 32'(e.data));
        chk("sb_crc_err", 32'(bus.out_crc_err), 32'(e.crc_err));
      end
    end else begin
      chk("hold_data", 32'(bus.out_data), 32'(m_data));
      chk("hold_crc_err", 32'(bus.out_crc_err), 32'(m_cerr));
    end
    chk("locked", 32'(bus.locked), 32'(m_locked));
    chk("err_cnt", 32'(bus.err_cnt), 32'(m_err));
  endtask

  // One clock of stimulus: check previous result, drive, advance the model.
  task automatic step(input logic v, input logic [12:0] d, input logic [7:0] c,
                      input logic clr, input logic r);
    logic bad;
    @(negedge clk);
    if (chk_en) check_outputs();
    bus.in_valid    = v;
    bus.in_data     = d;
    bus.in_crc      = c;
    bus.err_cnt_clr = clr;
    rst             = r;
    if (r) begin
      m_ov = 1'b0; m_data = '0; m_cerr = 1'b0; m_locked = 1'b0;
      m_err = '0; m_good = 0; m_bad = 0;
      q.delete();
    end else begin
      bad  = v && (crc_rem({d, c}) != 8'h00);
      m_ov = v;
      if (v) begin
        m_data = d;
        m_cerr = bad;
        q.push_back('{data: d, crc_err: bad});
        if (!m_locked) begin
          if (bad) m_good = 0;
          else if (m_good + 1 == int'(LOCK_GOOD)) begin
            m_locked = 1'b1; m_good = 0; m_bad = 0;
          end else m_good++;
        end else begin
          if (!bad) m_bad = 0;
          else if (m_bad + 1 == int'(UNLOCK_BAD)) begin
            m_locked = 1'b0; m_good = 0; m_bad = 0;
          end else m_bad++;
        end
      end
      if (bad) m_err = clr ? 16'd1 : ((m_err == 16'hFFFF) ? m_err : m_err + 16'd1);
      else if (clr) m_err = '0;
    end
    chk_en = 1'b1;
  endtask

  task automatic good_word();
    logic [12:0] d;
    d = 13'($urandom);
    step(1'b1, d, crc_ref(d), 1'b0, 1'b0);
  endtask

  task automatic bad_word(input logic clr);
    logic [12:0] d;
    d = 13'($urandom);
    step(1'b1, d, crc_ref(d) ^ 8'h01, clr, 1'b0);
  endtask

  task automatic idle(input logic clr);
    step(1'b0, 13'($urandom), 8'($urandom), clr, 1'b0);
  endtask

  task automatic do_reset();
    step(1'b0, '0, '0, 1'b0, 1'b1);
    step(1'b0, '0, '0, 1'b0, 1'b1);
  endtask

  // Wait until just after the edge that registers the last driven step.
  task automatic observe();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] e0;
    logic [20:0] w;
    logic [12:0] d;
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_crc = '0; bus.err_cnt_clr = 1'b0;

    // Reset values
    do_reset();
    observe();
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data", 32'(bus.out_data), 32'd0);
    chk("rst_locked", 32'(bus.locked), 32'd0);
    chk("rst_err_cnt", 32'(bus.err_cnt), 32'd0);

    // Known CRC vectors, then the same words with CRC bit 0 flipped
    step(1'b1, 13'h0001, 8'h07, 1'b0, 1'b0); observe();
    chk("vec1_good", 32'(bus.out_crc_err), 32'd0);
    step(1'b1, 13'h1000, 8'h57, 1'b0, 1'b0); observe();
    chk("vec2_good", 32'(bus.out_crc_err), 32'd0);
    step(1'b1, 13'h0001, 8'h06, 1'b0, 1'b0); observe();
    chk("vec1_bad", 32'(bus.out_crc_err), 32'd1);
    chk("vec1_bad_cnt", 32'(bus.err_cnt), 32'd1);
    step(1'b1, 13'h1000, 8'h56, 1'b0, 1'b0); observe();
    chk("vec2_bad", 32'(bus.out_crc_err), 32'd1);
    chk("vec2_bad_cnt", 32'(bus.err_cnt), 32'd2);

    // Lock acquisition: 15 good words stay in HUNT, the 16th locks
    do_reset();
    for (int i = 0; i < 15; i++) good_word();
    observe();
    chk("lock_after15", 32'(bus.locked), 32'd0);
    good_word(); observe();
    chk("lock_at16", 32'(bus.locked), 32'd1);
    chk("lock_at16_valid", 32'(bus.out_valid), 32'd1);

    // A bad word at position 10 restarts the run of 16
    do_reset();
    for (int i = 0; i < 9; i++) good_word();
    bad_word(1'b0);
    for (int i = 0; i < 15; i++) good_word();
    observe();
    chk("relock_after15", 32'(bus.locked), 32'd0);
    good_word(); observe();
    chk("relock_at16", 32'(bus.locked), 32'd1);

    // Unlock: 3 bad, 1 good, 3 bad keeps lock; the 4th consecutive bad drops it
    e0 = m_err;
    for (int i = 0; i < 3; i++) bad_word(1'b0);
    good_word();
    for (int i = 0; i < 3; i++) bad_word(1'b0);
    observe();
    chk("unlock_hold", 32'(bus.locked), 32'd1);
    bad_word(1'b0); observe();
    chk("unlock_drop", 32'(bus.locked), 32'd0);
    chk("unlock_err_delta", 32'(bus.err_cnt), 32'(e0 + 16'd7));

    // Gaps: idle cycles must not advance the lock count
    do_reset();
    for (int i = 0; i < 15; i++) begin
      good_word();
      idle(1'b0);
    end
    for (int i = 0; i < 3; i++) idle(1'b0);
    observe();
    chk("gap_no_advance", 32'(bus.locked), 32'd0);
    good_word(); observe();
    chk("gap_lock", 32'(bus.locked), 32'd1);

    // Full rate for 64 cycles with mixed words
    for (int i = 0; i < 64; i++) begin
      if ($urandom_range(3, 0) == 0) bad_word(1'b0);
      else good_word();
    end

    // 1000 random words, half with a single corrupted bit
    for (int i = 0; i < 1000; i++) begin
      d = 13'($urandom);
      w = {d, crc_ref(d)};
      if ($urandom_range(1, 0) == 1) w[$urandom_range(20, 0)] ^= 1'b1;
      step(1'b1, w[20:8], w[7:0], 1'b0, 1'b0);
    end

    // err_cnt saturation and clear interactions
    idle(1'b1); observe();
    chk("clr_alone_0", 32'(bus.err_cnt), 32'd0);
    for (int i = 0; i < 65534; i++) bad_word(1'b0);
    observe();
    chk("err_fffe", 32'(bus.err_cnt), 32'hFFFE);
    for (int i = 0; i < 3; i++) bad_word(1'b0);
    observe();
    chk("err_sat", 32'(bus.err_cnt), 32'hFFFF);
    bad_word(1'b1); observe();
    chk("clr_with_bad", 32'(bus.err_cnt), 32'd1);
    idle(1'b1); observe();
    chk("clr_alone", 32'(bus.err_cnt), 32'd0);

    // Reset mid-operation while locked with err_cnt=5
    do_reset();
    for (int i = 0; i < 16; i++) good_word();
    for (int i = 0; i < 5; i++) begin
      bad_word(1'b0);
      good_word();
    end
    observe();
    chk("pre_rst_locked", 32'(bus.locked), 32'd1);
    chk("pre_rst_err", 32'(bus.err_cnt), 32'd5);
    d = 13'($urandom);
    step(1'b1, d, crc_ref(d), 1'b0, 1'b1); observe();
    chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_locked", 32'(bus.locked), 32'd0);
    chk("mid_rst_err", 32'(bus.err_cnt), 32'd0);
    for (int i = 0; i < 15; i++) good_word();
    observe();
    chk("post_rst_15", 32'(bus.locked), 32'd0);
    good_word(); observe();
    chk("post_rst_16", 32'(bus.locked), 32'd1);

    idle(1'b0);
    idle(1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule

// File: doc/pflink_crc8_checker.md
# pflink_crc8_checker

Receive-side CRC checker for the pflink 13-bit word stream. Each incoming word carries 13 data bits plus the 8-bit CRC produced by the transmit-side generator (polynomial x^8+x^2+x+1, initial value 0, no final XOR, first serial bit d[12]). The block verifies every word and forwards the data with a per-word error flag. It tracks link lock with a hunt/locked state machine and keeps a saturating error counter for slow-control readout.

## Interface
Parameters:
- LOCK_GOOD, 16: consecutive good words needed to enter LOCKED (1..255)
- UNLOCK_BAD, 4: consecutive bad words needed to drop back to HUNT (1..255)

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  in_data/in_crc valid this cycle
- in_data  in  13  received data word
- in_crc  in  8  received CRC byte
- err_cnt_clr  in  1  synchronous clear of err_cnt
- out_valid  out  1  registered copy of in_valid
- out_data  out  13  registered in_data
- out_crc_err  out  1  1 = CRC mismatch for the word on out_data
- locked  out  1  1 = state LOCKED
- err_cnt  out  16  saturating count of bad words

## Operation
- Expected CRC: the 8-bit CRC of in_data (13 bits, MSB first, init 0, poly 0x07), computed combinationally. Word is good iff expected == in_crc; equivalently the CRC over the 21 bits {in_data,in_crc} is 0.
- Reset values: out_valid=0, out_data=0, out_crc_err=0, locked=0, err_cnt=0, state=HUNT, good_cnt=0, bad_cnt=0.
- Data path: whenever in_valid=1, register out_data<=in_data and out_crc_err<=(mismatch). When in_valid=0, out_valid<=0, and out_data/out_crc_err hold their previous values. Bad words are still forwarded; downstream uses out_crc_err.
- State machine (advances only on in_valid=1):
  - HUNT: good word -> good_cnt+1; when the increment reaches LOCK_GOOD, go to LOCKED, good_cnt<=0, bad_cnt<=0. Bad word -> good_cnt<=0.
  - LOCKED: bad word -> bad_cnt+1; when the increment reaches UNLOCK_BAD, go to HUNT, bad_cnt<=0, good_cnt<=0. Good word -> bad_cnt<=0.
  - locked is a registered decode of the state (1 in LOCKED).
- err_cnt: increments on every bad word in either state and saturates at 16'hFFFF. err_cnt_clr alone sets it to 0. err_cnt_clr together with a bad word sets it to 1. err_cnt_clr does not affect the state machine.
- Counters good_cnt and bad_cnt are 8 bits wide and cannot overflow, because they reset on reaching their thresholds.

## Timing
- Latency: 1 cycle. Word presented at edge N appears on out_* after edge N+1, with out_valid=1 for exactly that cycle.
- Back-to-back words at full rate (in_valid held high) are supported with no bubbles.
- A word that completes a lock or unlock count changes locked in the same cycle that word's out_valid is high.
- err_cnt updates in the same cycle as the corresponding out_valid.
- rst mid-stream: on the next edge all outputs and internal state go to reset values, and any word present in the rst cycle is discarded (out_valid=0 next cycle).
- No backpressure; the block never stalls the input.

## Test plan
- CRC vectors: in_data=13'h0001 with in_crc=8'h07, and in_data=13'h1000 with in_crc=8'h57 -> out_crc_err=0. Same words with in_crc bit 0 flipped -> out_crc_err=1 and err_cnt increments by 1 each. Also check against a reference model for 1000 random words with random single-bit corruptions.
- Lock acquisition: after reset, 15 good words -> locked=0; the 16th good word -> locked=1 in its out_valid cycle. Repeat with a bad word inserted at position 10 -> lock requires 16 further consecutive good words.
- Unlock: while LOCKED, send 3 bad, 1 good, 3 bad -> locked stays 1. Then 1 more bad (4 consecutive) -> locked=0. Verify err_cnt increased by 7 over the sequence.
- Throughput and gaps: alternate in_valid 1/0 and hold in_valid=1 for 64 cycles. out_valid must mirror in_valid delayed by exactly 1 cycle, out_data must match, and the state machine must not advance on idle cycles.
- err_cnt edges: force err_cnt to 16'hFFFE via 65534 bad words, then 3 more -> err_cnt=16'hFFFF held. Assert err_cnt_clr together with a bad word -> err_cnt=1. Assert err_cnt_clr alone -> 0.
- Reset mid-operation: while LOCKED with err_cnt=5, assert rst for 1 cycle with in_valid=1 -> next cycle out_valid=0, locked=0, err_cnt=0. A subsequent lock requires a full 16 good words.
